// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   state_t   : controller state encoding (IDLE, RUN, DONE)
//   cnt_width : bit-counter width for a given operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bits needed to count 0..w-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/half_adder.sv
// One-bit half adder.
//   a, b : addend bits
//   s    : sum bit
//   c    : carry bit
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_slice.sv
// Combinational one-bit full adder: two half adders plus an OR for carry.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   co   : carry out
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (w_s1),
    .c (w_c1)
  );

  half_adder u_ha1 (
    .a (w_s1),
    .b (cin),
    .s (s),
    .c (w_c2)
  );

  // The two half-adder carries can never both be 1, so OR is exact.
  assign co = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. One full-adder slice is reused over WIDTH
// cycles, LSB first, with the carry held in a flop between cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   a, b       : operands, captured when start is accepted
//   busy       : high while the add is in progress
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : registered result, held until the next completion
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_s_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_s_bit;
  logic               w_c_bit;
  logic               w_last;

  serial_fa_slice u_slice (
    .a   (r_a_sr[0]),
    .b   (r_b_sr[0]),
    .cin (r_carry),
    .s   (w_s_bit),
    .co  (w_c_bit)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // Datapath: operand/sum shift registers, carry, counter, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_s_sr  <= {w_s_bit, r_s_sr[WIDTH-1:1]};
          r_carry <= w_c_bit;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Final bit: publish the assembled word including this cycle's bit.
          if (w_last) begin
            r_sum  <= {w_s_bit, r_s_sr[WIDTH-1:1]};
            r_cout <= w_c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One 8-bit operation; expected {cout,sum} goes to the scoreboard on drive.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] es, input logic ec, input bit hold_chk);
    int n;
    int nbusy;
    int bad_hold;
    int overlap;
    bit seen;
    logic [8:0] held;
    logic [8:0] exp;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back({ec, es});
    held = {cout8, sum8};
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = 8'($urandom);
    n = 0; nbusy = 0; bad_hold = 0; overlap = 0; seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (busy8) nbusy++;
      if (busy8 && done8) overlap++;
      if (done8) seen = 1;
      else if ({cout8, sum8} !== held) bad_hold++;
    end
    chk("done8_seen", 64'(seen), 64'd1);
    chk("done8_latency", 64'(n), 64'd9);
    chk("busy8_cycles", 64'(nbusy), 64'd8);
    chk("busy_done_overlap", 64'(overlap), 64'd0);
    if (seen && q8.size() > 0) begin
      exp = q8.pop_front();
      chk("result8", {55'd0, cout8, sum8}, {55'd0, exp});
    end else begin
      chk("scoreboard8_nonempty", 64'(q8.size()), 64'd1);
    end
    if (hold_chk) chk("sum_held_until_done", 64'(bad_hold), 64'd0);
    @(negedge clk);
    chk("done8_one_cycle", {63'd0, done8}, 64'd0);
  endtask

  initial begin
    int dcount;
    int bad;
    int lat_bad;
    int res_bad;
    logic [8:0] exp;

    vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[1] = '{8'h5A, 8'hA5, 8'hFF, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h7F, 8'hFE, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'h3C, 8'h0F, 8'h4B, 1'b0};
    vecs[7] = '{8'h10, 8'h20, 8'h30, 1'b0};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_done", {63'd0, done8}, 64'd0);
    chk("rst_sum", {56'd0, sum8}, 64'h00);
    chk("rst_cout", {63'd0, cout8}, 64'd0);
    chk("rst_state4", {58'd0, busy4, done4, cout4, sum4}, 64'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin @(negedge clk); if (done8 || busy8) bad++; end
    chk("idle_no_done", 64'(bad), 64'd0);

    // Table-driven vectors; vecs[2] checks the prior sum holds until done
    for (int i = 0; i < 8; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_cout, i == 2);

    // Start while busy and during DONE: only the first is accepted
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
    q8.push_back({1'b0, 8'h07});
    @(posedge clk); #1;
    start8 = 1'b0;
    dcount = 0;
    bad = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) begin a8 = 8'h55; b8 = 8'h11; start8 = 1'b1; end
      else start8 = 1'b0;
      if (done8) begin
        dcount++;
        if (q8.size() > 0) begin
          exp = q8.pop_front();
          chk("busy_start_result", {55'd0, cout8, sum8}, {55'd0, exp});
        end
        a8 = 8'hAA; b8 = 8'h22; start8 = 1'b1;
      end
      if (c > 11 && busy8) bad++;
    end
    start8 = 1'b0;
    chk("busy_start_one_done", 64'(dcount), 64'd1);
    chk("done_start_ignored", 64'(bad), 64'd0);
    chk("busy_start_sum_kept", {55'd0, cout8, sum8}, {55'd0, 9'h007});
    op8(8'h21, 8'h12, 8'h33, 1'b0, 1'b0);

    // Reset mid-operation
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
    q8.push_back({1'b0, 8'hFF});
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {54'd0, busy8, done8, cout8, sum8}, 64'd0);
    q8.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin @(negedge clk); if (done8 || busy8) bad++; end
    chk("midrst_no_done", 64'(bad), 64'd0);
    op8(8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    // Exhaustive 4-bit
    lat_bad = 0;
    res_bad = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        int n;
        bit seen;
        logic [4:0] e4;
        @(negedge clk);
        a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
        q4.push_back(5'(ia) + 5'(ib));
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'(~ia); b4 = 4'(~ib);
        n = 0; seen = 0;
        while (!seen && n < 20) begin
          @(negedge clk);
          n++;
          if (done4) seen = 1;
        end
        if (!seen || n != 5) lat_bad++;
        if (seen && q4.size() > 0) begin
          e4 = q4.pop_front();
          if ({cout4, sum4} !== e4) begin
            res_bad++;
            if (res_bad <= 5)
              $display("FAIL exh4 %0h+%0h: got %0h expected %0h", ia, ib, {cout4, sum4}, e4);
          end
        end else begin
          res_bad++;
        end
      end
    end
    chk("exh4_latency_errors", 64'(lat_bad), 64'd0);
    chk("exh4_result_errors", 64'(res_bad), 64'd0);
    chk("exh4_scoreboard_empty", 64'(q4.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
